dmem_line_arbiter: RTL and testbench
====================================

Name: dmem_line_arbiter

Overview:
- Sequences and shares the single line-wide data memory (d_mem) between the two CPU cache/line interfaces (cpu0, cpu1).
- Each CPU issues one line read or write (11-bit line address, 64-bit line). The arbiter grants round-robin, drives one memory access at a time, and returns read data and completion per CPU.
- Sits in smp between the CPUs' line ports and d_mem. Includes a watchdog so a stalled memory cannot hang a CPU.

Parameters:
- AW, 11, line address width
- DW, 64, line data width
- TIMEOUT, 255, max cycles in ACCESS waiting for mem_rdy before abort (1..65535)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous active-high reset
- u_addr_0  in  AW  cpu0 line address
- u_re_0  in  1  cpu0 line read request (level, held until u_rdy_0)
- u_we_0  in  1  cpu0 line write request (level, held until u_rdy_0)
- d_line_0  in  DW  cpu0 write line
- u_rd_data_0  out  DW  cpu0 read line, registered
- u_rdy_0  out  1  cpu0 completion pulse
- u_err_0  out  1  cpu0 abort flag, valid with u_rdy_0
- u_addr_1, u_re_1, u_we_1, d_line_1, u_rd_data_1, u_rdy_1, u_err_1: same as the cpu0 signals, for cpu1
- grant  out  2  one-hot owner of memory ({cpu1,cpu0}); 00 when idle
- mem_addr  out  AW  address to d_mem
- mem_re  out  1  read strobe to d_mem (level for whole access)
- mem_we  out  1  write strobe to d_mem (level for whole access)
- mem_wdata  out  DW  write line to d_mem
- mem_rd_data  in  DW  read line from d_mem
- mem_rdy  in  1  d_mem access complete, sampled each ACCESS cycle
- timeout  out  1  sticky; set on any abort, cleared only by rst

Behaviour:
Reset:
- rst sampled high forces IDLE.
- All outputs go to 0: grant=00, mem_re/we=0, u_rdy_x=0, u_err_x=0, u_rd_data_x=0, timeout=0.
- Round-robin pointer set so cpu0 wins the first tie.
- Watchdog counter cleared.
- Reset mid-access abandons the access. No u_rdy is produced for it.

Requests:
- req_x = u_re_x | u_we_x.
- If both u_re_x and u_we_x are set, the access is a write (we dominates).
- The requester must hold addr/data/strobe stable until it sees u_rdy_x. It deasserts at the clock edge ending the u_rdy_x cycle.

FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requesting: grant the CPU not served last.
  - On grant, latch the owner's addr, data and op into mem_* registers. Next state ACCESS. grant and mem_re/mem_we go high from the first ACCESS cycle.
- ACCESS:
  - mem_* held constant; watchdog counts.
  - mem_rdy=1: capture mem_rd_data into u_rd_data_owner (reads only; writes leave it unchanged). Drop mem_re/mem_we and grant. Next state RESP.
  - Watchdog reaches TIMEOUT without mem_rdy: drop strobes, set u_err pending, set timeout, leave u_rd_data unchanged. Next state RESP.
- RESP:
  - u_rdy_owner=1 for exactly one cycle. u_err_owner=1 that cycle only if aborted.
  - Update the round-robin pointer to the owner. Next state IDLE.
  - The non-owner's outputs stay 0.

Latency:
- Request first sampled in IDLE at cycle T.
- mem strobes are asserted T+1..T+k, with mem_rdy seen at T+k (k≥1).
- u_rdy at T+k+1.
- Minimum 3-cycle request-to-rdy; minimum IDLE gap of 1 cycle between accesses.

Fairness and simultaneous events:
- A request arriving while the other CPU is being served waits, and is granted in the next IDLE.
- Back-to-back requests from both CPUs strictly alternate.
- A CPU dropping its request before grant is permitted; nothing is issued.
- A CPU dropping its request after grant is ignored; the access completes and u_rdy still pulses.
- mem_rdy outside ACCESS is ignored.

Watchdog:
- Counts ACCESS cycles from 1 and is cleared on entering ACCESS.
- Abort occurs when the count reaches TIMEOUT with mem_rdy low.
- mem_rdy in the same cycle as reaching TIMEOUT is a success; mem_rdy has priority.

Test Plan:
- cpu0 read, addr=11'h005, mem_rdy 2 cycles after mem_re with mem_rd_data=64'hDEAD_BEEF_0123_4567 -> mem_addr=005, mem_re high 2 cycles, u_rd_data_0 equals that value, u_rdy_0 one-cycle pulse 3 cycles after request start, grant=01 during access.
- cpu1 write, addr=11'h7FF, d_line_1=64'hA5A5...A5, mem_rdy immediate -> mem_we=1 and mem_wdata=A5.., u_rdy_1 pulse, u_rd_data_1 stays 0, u_err_1=0.
- Both CPUs request reads in the same cycle, held continuously for 4 transactions each -> grant sequence 01,10,01,10,...; no CPU is granted twice in a row while the other waits.
- cpu0 read with mem_rdy never asserted, TIMEOUT=8 -> strobes drop after 8 ACCESS cycles, u_rdy_0=u_err_0=1 for one cycle, timeout stays 1, the next cpu1 request is serviced normally.
- rst asserted during ACCESS of a cpu1 write -> next cycle all outputs 0, state IDLE, no u_rdy_1; a subsequent simultaneous request grants cpu0 first.
- cpu0 sets u_re_0 and u_we_0 together -> a write is issued (mem_we=1, mem_re=0); mem_rdy exactly at watchdog count TIMEOUT -> success, u_err_0=0.

Source files
------------

// File: rtl/dmem_line_arbiter_if.sv
// Bus bundle between the two CPU line ports, the arbiter and d_mem.
// The "master" side is the environment (both CPUs plus the memory);
// the "slave" side is the arbiter that sits in the middle.
interface dmem_line_arbiter_if #(
  parameter int AW = 11,
  parameter int DW = 64
);
  // cpu0 line port
  logic [AW-1:0] u_addr_0;
  logic          u_re_0;
  logic          u_we_0;
  logic [DW-1:0] d_line_0;
  logic [DW-1:0] u_rd_data_0;
  logic          u_rdy_0;
  logic          u_err_0;

  // cpu1 line port
  logic [AW-1:0] u_addr_1;
  logic          u_re_1;
  logic          u_we_1;
  logic [DW-1:0] d_line_1;
  logic [DW-1:0] u_rd_data_1;
  logic          u_rdy_1;
  logic          u_err_1;

  // d_mem port
  logic [AW-1:0] mem_addr;
  logic          mem_re;
  logic          mem_we;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rd_data;
  logic          mem_rdy;

  modport master (
    output u_addr_0, u_re_0, u_we_0, d_line_0,
    input  u_rd_data_0, u_rdy_0, u_err_0,
    output u_addr_1, u_re_1, u_we_1, d_line_1,
    input  u_rd_data_1, u_rdy_1, u_err_1,
    input  mem_addr, mem_re, mem_we, mem_wdata,
    output mem_rd_data, mem_rdy
  );

  modport slave (
    input  u_addr_0, u_re_0, u_we_0, d_line_0,
    output u_rd_data_0, u_rdy_0, u_err_0,
    input  u_addr_1, u_re_1, u_we_1, d_line_1,
    output u_rd_data_1, u_rdy_1, u_err_1,
    output mem_addr, mem_re, mem_we, mem_wdata,
    input  mem_rd_data, mem_rdy
  );
endinterface

// File: rtl/dmem_line_arbiter.sv
// Round-robin arbiter sharing one line-wide data memory between two CPUs.
// One access is in flight at a time: IDLE picks an owner and latches its
// request, ACCESS holds the memory strobes until mem_rdy or the watchdog
// expires, RESP returns a one-cycle completion (with error on abort).
module dmem_line_arbiter #(
  parameter int AW      = 11,
  parameter int DW      = 64,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  dmem_line_arbiter_if.slave bus,
  output logic [1:0]         grant,
  output logic               timeout
);

  localparam logic [15:0] TIMEOUT_C = 16'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_RESP
  } state_t;

  typedef enum logic {
    CPU0 = 1'b0,
    CPU1 = 1'b1
  } cpu_t;

  state_t        state_q,     state_d;
  cpu_t          owner_q,     owner_d;
  cpu_t          last_q,      last_d;
  logic [15:0]   wdog_q,      wdog_d;
  logic [1:0]    grant_q,     grant_d;
  logic [AW-1:0] mem_addr_q,  mem_addr_d;
  logic [DW-1:0] mem_wdata_q, mem_wdata_d;
  logic          mem_re_q,    mem_re_d;
  logic          mem_we_q,    mem_we_d;
  logic [DW-1:0] rd_data_0_q, rd_data_0_d;
  logic [DW-1:0] rd_data_1_q, rd_data_1_d;
  logic          rdy_0_q,     rdy_0_d;
  logic          rdy_1_q,     rdy_1_d;
  logic          err_0_q,     err_0_d;
  logic          err_1_q,     err_1_d;
  logic          timeout_q,   timeout_d;

  logic req_0;
  logic req_1;
  cpu_t pick;

  assign req_0 = bus.u_re_0 | bus.u_we_0;
  assign req_1 = bus.u_re_1 | bus.u_we_1;

  // Choose the next owner: a lone requester wins, a tie goes to the CPU not served last.
  always_comb begin
    pick = CPU0;
    if (req_0 && req_1) begin
      pick = (last_q == CPU0) ? CPU1 : CPU0;
    end else if (req_1) begin
      pick = CPU1;
    end
  end

  // Next-state and output computation for the IDLE/ACCESS/RESP sequence.
  always_comb begin
    // NOTE: every variable gets its hold/idle value first so no path leaves
    // one unassigned; a missing default here would infer a latch.
    state_d     = state_q;
    owner_d     = owner_q;
    last_d      = last_q;
    wdog_d      = wdog_q;
    grant_d     = grant_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_re_d    = mem_re_q;
    mem_we_d    = mem_we_q;
    rd_data_0_d = rd_data_0_q;
    rd_data_1_d = rd_data_1_q;
    rdy_0_d     = 1'b0;
    rdy_1_d     = 1'b0;
    err_0_d     = 1'b0;
    err_1_d     = 1'b0;
    timeout_d   = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_0 || req_1) begin
          owner_d = pick;
          // Watchdog counts ACCESS cycles starting from 1 in the first one.
          wdog_d  = 16'd1;
          state_d = S_ACCESS;
          if (pick == CPU1) begin
            grant_d     = 2'b10;
            mem_addr_d  = bus.u_addr_1;
            mem_wdata_d = bus.d_line_1;
            mem_we_d    = bus.u_we_1;
            mem_re_d    = bus.u_re_1 & ~bus.u_we_1;
          end else begin
            grant_d     = 2'b01;
            mem_addr_d  = bus.u_addr_0;
            mem_wdata_d = bus.d_line_0;
            mem_we_d    = bus.u_we_0;
            mem_re_d    = bus.u_re_0 & ~bus.u_we_0;
          end
        end
      end

      S_ACCESS: begin
        // mem_rdy is checked before the watchdog so a completion in the
        // same cycle the count hits TIMEOUT is still a success.
        if (bus.mem_rdy) begin
          if (mem_re_q) begin
            if (owner_q == CPU1) rd_data_1_d = bus.mem_rd_data;
            else                 rd_data_0_d = bus.mem_rd_data;
          end
          grant_d  = 2'b00;
          mem_re_d = 1'b0;
          mem_we_d = 1'b0;
          if (owner_q == CPU1) rdy_1_d = 1'b1;
          else                 rdy_0_d = 1'b1;
          state_d  = S_RESP;
        end else if (wdog_q == TIMEOUT_C) begin
          grant_d   = 2'b00;
          mem_re_d  = 1'b0;
          mem_we_d  = 1'b0;
          timeout_d = 1'b1;
          if (owner_q == CPU1) begin
            rdy_1_d = 1'b1;
            err_1_d = 1'b1;
          end else begin
            rdy_0_d = 1'b1;
            err_0_d = 1'b1;
          end
          state_d   = S_RESP;
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
      end

      S_RESP: begin
        last_d  = owner_q;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; synchronous reset abandons any access in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments so every flop samples the pre-edge
    // value of its neighbours, independent of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      owner_q     <= CPU0;
      last_q      <= CPU1;
      wdog_q      <= '0;
      grant_q     <= 2'b00;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_re_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      rd_data_0_q <= '0;
      rd_data_1_q <= '0;
      rdy_0_q     <= 1'b0;
      rdy_1_q     <= 1'b0;
      err_0_q     <= 1'b0;
      err_1_q     <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      wdog_q      <= wdog_d;
      grant_q     <= grant_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_re_q    <= mem_re_d;
      mem_we_q    <= mem_we_d;
      rd_data_0_q <= rd_data_0_d;
      rd_data_1_q <= rd_data_1_d;
      rdy_0_q     <= rdy_0_d;
      rdy_1_q     <= rdy_1_d;
      err_0_q     <= err_0_d;
      err_1_q     <= err_1_d;
      timeout_q   <= timeout_d;
    end
  end

  assign grant           = grant_q;
  assign timeout         = timeout_q;
  assign bus.mem_addr    = mem_addr_q;
  assign bus.mem_wdata   = mem_wdata_q;
  assign bus.mem_re      = mem_re_q;
  assign bus.mem_we      = mem_we_q;
  assign bus.u_rd_data_0 = rd_data_0_q;
  assign bus.u_rd_data_1 = rd_data_1_q;
  assign bus.u_rdy_0     = rdy_0_q;
  assign bus.u_rdy_1     = rdy_1_q;
  assign bus.u_err_0     = err_0_q;
  assign bus.u_err_1     = err_1_q;

endmodule

// File: tb/tb_dmem_line_arbiter.sv
// Scoreboard bench for dmem_line_arbiter: directed CPU transactions push
// expected memory accesses and responses; independent monitors pop and
// compare whenever the DUT presents a memory access or a completion.
module tb_dmem_line_arbiter;

  localparam int AW = 11;
  localparam int DW = 64;
  localparam int TO = 8;

  typedef struct {
    logic [1:0]    grant;
    logic [AW-1:0] addr;
    logic          re;
    logic          we;
    logic [DW-1:0] wdata;
    int            len;
  } mem_exp_t;

  typedef struct {
    logic          err;
    logic [DW-1:0] data;
  } rsp_exp_t;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] grant;
  logic       timeout;

  dmem_line_arbiter_if #(.AW(AW), .DW(DW)) bus ();

  dmem_line_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (bus),
    .grant   (grant),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  mem_exp_t exp_mem[$];
  rsp_exp_t exp_rsp0[$];
  rsp_exp_t exp_rsp1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic mem_exp_t mk_mem(input logic [1:0] g, input logic [AW-1:0] a,
                                      input logic re, input logic we,
                                      input logic [DW-1:0] wd, input int len);
    mem_exp_t m;
    m.grant = g; m.addr = a; m.re = re; m.we = we; m.wdata = wd; m.len = len;
    return m;
  endfunction

  function automatic rsp_exp_t mk_rsp(input logic err, input logic [DW-1:0] d);
    rsp_exp_t r;
    r.err = err; r.data = d;
    return r;
  endfunction

  // Memory model: answers after mem_k strobe cycles unless mem_never is set.
  logic [DW-1:0] mem_array [int];
  int mem_k     = 1;
  bit mem_never = 1'b0;
  int acc_cnt   = 0;

  always @(negedge clk) begin
    if (bus.mem_re || bus.mem_we) begin
      acc_cnt++;
      if (!mem_never && acc_cnt == mem_k) begin
        bus.mem_rdy = 1'b1;
        if (bus.mem_we) begin
          mem_array[int'(bus.mem_addr)] = bus.mem_wdata;
          bus.mem_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
        end else begin
          bus.mem_rd_data = mem_array.exists(int'(bus.mem_addr)) ? mem_array[int'(bus.mem_addr)] : '0;
        end
      end else begin
        bus.mem_rdy     = 1'b0;
        bus.mem_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
      end
    end else begin
      acc_cnt         = 0;
      bus.mem_rdy     = 1'b0;
      bus.mem_rd_data = 64'hBAD0_BAD0_BAD0_BAD0;
    end
  end

  // Memory-side monitor: checks each access against the expected order and length.
  mem_exp_t cur;
  int       cur_len     = 0;
  bit       prev_strobe = 1'b0;
  bit       strobe_now;

  always @(negedge clk) begin
    strobe_now = bus.mem_re | bus.mem_we;
    if (strobe_now && !prev_strobe) begin
      check("mem_access_expected", 64'(exp_mem.size() > 0), 64'd1);
      if (exp_mem.size() > 0) begin
        cur = exp_mem.pop_front();
        check("mem_grant", 64'(grant), 64'(cur.grant));
        check("mem_addr",  64'(bus.mem_addr), 64'(cur.addr));
        check("mem_re",    64'(bus.mem_re), 64'(cur.re));
        check("mem_we",    64'(bus.mem_we), 64'(cur.we));
        if (cur.we) check("mem_wdata", bus.mem_wdata, cur.wdata);
      end else begin
        cur.len = -1;
      end
      cur_len = 1;
    end else if (strobe_now) begin
      cur_len++;
      check("mem_addr_hold", 64'(bus.mem_addr), 64'(cur.addr));
    end else if (prev_strobe) begin
      check("mem_strobe_len", 64'(cur_len), 64'(cur.len));
    end
    prev_strobe = strobe_now;
  end

  // Response monitor: pops the per-CPU expectation on every completion pulse.
  rsp_exp_t r0, r1;

  always @(negedge clk) begin
    if (bus.u_rdy_0) begin
      check("rsp0_expected", 64'(exp_rsp0.size() > 0), 64'd1);
      if (exp_rsp0.size() > 0) begin
        r0 = exp_rsp0.pop_front();
        check("rsp0_err",  64'(bus.u_err_0), 64'(r0.err));
        check("rsp0_data", bus.u_rd_data_0, r0.data);
      end
    end
    if (bus.u_rdy_1) begin
      check("rsp1_expected", 64'(exp_rsp1.size() > 0), 64'd1);
      if (exp_rsp1.size() > 0) begin
        r1 = exp_rsp1.pop_front();
        check("rsp1_err",  64'(bus.u_err_1), 64'(r1.err));
        check("rsp1_data", bus.u_rd_data_1, r1.data);
      end
    end
    if (bus.u_err_0 && !bus.u_rdy_0) check("err0_only_with_rdy", 64'(bus.u_err_0), 64'd0);
    if (bus.u_err_1 && !bus.u_rdy_1) check("err1_only_with_rdy", 64'(bus.u_err_1), 64'd0);
  end

  // One CPU transaction: raise the request, wait for u_rdy, drop at the edge ending it.
  // Called 1 time unit after a rising edge.
  task automatic cpu_access(input int cpu, input logic re, input logic we,
                            input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                            input rsp_exp_t exp, input int exp_lat);
    int n;
    bit got;
    if (cpu == 0) begin
      bus.u_addr_0 = addr; bus.u_re_0 = re; bus.u_we_0 = we; bus.d_line_0 = wdata;
      exp_rsp0.push_back(exp);
    end else begin
      bus.u_addr_1 = addr; bus.u_re_1 = re; bus.u_we_1 = we; bus.d_line_1 = wdata;
      exp_rsp1.push_back(exp);
    end
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      if ((cpu == 0) ? bus.u_rdy_0 : bus.u_rdy_1) got = 1'b1;
      else n++;
    end
    check((cpu == 0) ? "cpu0_rdy_seen" : "cpu1_rdy_seen", 64'(got), 64'd1);
    if (got && exp_lat > 0) check((cpu == 0) ? "cpu0_latency" : "cpu1_latency", 64'(n), 64'(exp_lat));
    @(posedge clk);
    #1;
    if (cpu == 0) begin
      bus.u_re_0 = 1'b0; bus.u_we_0 = 1'b0;
    end else begin
      bus.u_re_1 = 1'b0; bus.u_we_1 = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish (t=%0t)", $time);
    $fatal(1, "global timeout");
  end

  logic [DW-1:0] tbl0 [4];
  logic [DW-1:0] tbl1 [4];

  initial begin
    int n;

    tbl0[0] = 64'h0000_1111_2222_3333; tbl0[1] = 64'h4444_5555_6666_7777;
    tbl0[2] = 64'h8888_9999_AAAA_BBBB; tbl0[3] = 64'hCCCC_DDDD_EEEE_FFFF;
    tbl1[0] = 64'h1010_1010_1010_1010; tbl1[1] = 64'h2020_2020_2020_2020;
    tbl1[2] = 64'h4040_4040_4040_4040; tbl1[3] = 64'h8080_8080_8080_8080;

    mem_array[32'h005] = 64'hDEAD_BEEF_0123_4567;
    for (int i = 0; i < 4; i++) begin
      mem_array[32'h100 + i] = tbl0[i];
      mem_array[32'h200 + i] = tbl1[i];
    end
    mem_array[32'h020] = 64'hFFFF_0000_FFFF_0000;
    mem_array[32'h030] = 64'h3030_3030_3030_3030;
    mem_array[32'h060] = 64'h6060_6060_6060_6060;
    mem_array[32'h061] = 64'h6161_6161_6161_6161;

    rst = 1'b1;
    bus.u_addr_0 = '0; bus.u_re_0 = 1'b0; bus.u_we_0 = 1'b0; bus.d_line_0 = '0;
    bus.u_addr_1 = '0; bus.u_re_1 = 1'b0; bus.u_we_1 = 1'b0; bus.d_line_1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);

    // Reset state
    check("rst_grant",     64'(grant), 64'd0);
    check("rst_mem_re",    64'(bus.mem_re), 64'd0);
    check("rst_mem_we",    64'(bus.mem_we), 64'd0);
    check("rst_rdy0",      64'(bus.u_rdy_0), 64'd0);
    check("rst_rdy1",      64'(bus.u_rdy_1), 64'd0);
    check("rst_rd_data0",  bus.u_rd_data_0, 64'd0);
    check("rst_rd_data1",  bus.u_rd_data_1, 64'd0);
    check("rst_timeout",   64'(timeout), 64'd0);

    @(posedge clk);
    #1 rst = 1'b0;

    // cpu0 read, mem_rdy in the 2nd access cycle -> rdy 3 cycles after request
    mem_k = 2; mem_never = 1'b0;
    exp_mem.push_back(mk_mem(2'b01, 11'h005, 1'b1, 1'b0, '0, 2));
    cpu_access(0, 1'b1, 1'b0, 11'h005, '0, mk_rsp(1'b0, 64'hDEAD_BEEF_0123_4567), 3);

    // cpu1 write to the top line, immediate mem_rdy; read data stays at 0
    mem_k = 1;
    exp_mem.push_back(mk_mem(2'b10, 11'h7FF, 1'b0, 1'b1, {8{8'hA5}}, 1));
    cpu_access(1, 1'b0, 1'b1, 11'h7FF, {8{8'hA5}}, mk_rsp(1'b0, 64'd0), 2);

    // Both CPUs read back-to-back: grants must alternate starting with cpu0
    mem_k = 1;
    for (int i = 0; i < 4; i++) begin
      exp_mem.push_back(mk_mem(2'b01, 11'h100 + 11'(i), 1'b1, 1'b0, '0, 1));
      exp_mem.push_back(mk_mem(2'b10, 11'h200 + 11'(i), 1'b1, 1'b0, '0, 1));
    end
    fork
      begin
        for (int i = 0; i < 4; i++)
          cpu_access(0, 1'b1, 1'b0, 11'h100 + 11'(i), '0, mk_rsp(1'b0, tbl0[i]), 0);
      end
      begin
        for (int j = 0; j < 4; j++)
          cpu_access(1, 1'b1, 1'b0, 11'h200 + 11'(j), '0, mk_rsp(1'b0, tbl1[j]), 0);
      end
    join

    // cpu0 read with a stalled memory: abort after 8 access cycles
    mem_never = 1'b1;
    exp_mem.push_back(mk_mem(2'b01, 11'h020, 1'b1, 1'b0, '0, 8));
    cpu_access(0, 1'b1, 1'b0, 11'h020, '0, mk_rsp(1'b1, tbl0[3]), 9);
    check("timeout_set", 64'(timeout), 64'd1);

    // cpu1 serviced normally after the abort; timeout remains sticky
    mem_never = 1'b0; mem_k = 1;
    exp_mem.push_back(mk_mem(2'b10, 11'h030, 1'b1, 1'b0, '0, 1));
    cpu_access(1, 1'b1, 1'b0, 11'h030, '0, mk_rsp(1'b0, 64'h3030_3030_3030_3030), 2);
    check("timeout_sticky", 64'(timeout), 64'd1);

    // re+we together is a write; mem_rdy exactly at the TIMEOUT count is a success
    mem_k = 8;
    exp_mem.push_back(mk_mem(2'b01, 11'h055, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 8));
    cpu_access(0, 1'b1, 1'b1, 11'h055, 64'h0123_4567_89AB_CDEF, mk_rsp(1'b0, tbl0[3]), 9);

    // Reset in the middle of a cpu1 write: everything clears, no u_rdy_1
    mem_never = 1'b1;
    exp_mem.push_back(mk_mem(2'b10, 11'h040, 1'b0, 1'b1, {4{16'h5555}}, 2));
    bus.u_addr_1 = 11'h040; bus.u_we_1 = 1'b1; bus.d_line_1 = {4{16'h5555}};
    n = 0;
    while (!bus.mem_we && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("rst_mid_access_started", 64'(bus.mem_we), 64'd1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("rstmid_grant",    64'(grant), 64'd0);
    check("rstmid_mem_re",   64'(bus.mem_re), 64'd0);
    check("rstmid_mem_we",   64'(bus.mem_we), 64'd0);
    check("rstmid_mem_addr", 64'(bus.mem_addr), 64'd0);
    check("rstmid_rdy1",     64'(bus.u_rdy_1), 64'd0);
    check("rstmid_err1",     64'(bus.u_err_1), 64'd0);
    check("rstmid_timeout",  64'(timeout), 64'd0);
    check("rstmid_rd_data0", bus.u_rd_data_0, 64'd0);
    check("rstmid_rd_data1", bus.u_rd_data_1, 64'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.u_we_1 = 1'b0; bus.d_line_1 = '0;
    mem_never = 1'b0; mem_k = 1;

    // Simultaneous requests after reset: cpu0 wins the first tie
    exp_mem.push_back(mk_mem(2'b01, 11'h060, 1'b1, 1'b0, '0, 1));
    exp_mem.push_back(mk_mem(2'b10, 11'h061, 1'b1, 1'b0, '0, 1));
    fork
      cpu_access(0, 1'b1, 1'b0, 11'h060, '0, mk_rsp(1'b0, 64'h6060_6060_6060_6060), 2);
      cpu_access(1, 1'b1, 1'b0, 11'h061, '0, mk_rsp(1'b0, 64'h6161_6161_6161_6161), 0);
    join

    repeat (5) @(posedge clk);
    @(negedge clk);
    check("mem_queue_drained",  64'(exp_mem.size()), 64'd0);
    check("rsp0_queue_drained", 64'(exp_rsp0.size()), 64'd0);
    check("rsp1_queue_drained", 64'(exp_rsp1.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
